dpram_rr_arbiter: RTL
=====================

Name: dpram_rr_arbiter

Overview:
Round-robin controller that shares the 32x8 dual-port RAM between two requesters. The RAM has one shared address bus and one write-data bus, so only one access can occur per cycle. Requester 0 is bound to RAM port A and requester 1 to port B. The block accepts req/gnt transactions, sequences the RAM enables and write enable, and returns read data with a valid pulse.

Parameters:
ADDR_W, 5, RAM address width (32 locations)
DATA_W, 8, RAM data width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0, req1  in  1 each  access request; held until the matching gnt
we0, we1  in  1 each  1 = write, 0 = read; stable while req is high
addr0, addr1  in  ADDR_W each  access address
wdata0, wdata1  in  DATA_W each  write data
gnt0, gnt1  out  1 each  one-cycle pulse; the RAM access is occurring this cycle
rvalid0, rvalid1  out  1 each  one-cycle pulse; rdata holds read result
rdata  out  DATA_W  registered read data, shared by both requesters
ram_addr  out  ADDR_W  to RAM addr
ram_data_in  out  DATA_W  to RAM data_in
ram_wr_en  out  1  to RAM wr_en
ram_port_A_enb, ram_port_B_enb  out  1 each  to RAM port enables
ram_data_out_A, ram_data_out_B  in  DATA_W each  from RAM outputs (registered, valid the cycle after the enable)

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - All gnt, rvalid, ram_* enables and ram_wr_en = 0.
  - ram_addr, ram_data_in, rdata = 0.
  - last_grant=1, so requester 0 wins the first contest.
- Reset asserted mid-transaction aborts it: no gnt or rvalid is issued afterwards. Requesters must re-request.
- FSM states: IDLE, ACC, RD.
- IDLE:
  - If any req is high, select a winner. If only one req is high, that requester wins. If both are high, the winner is the requester != last_grant.
  - Register the winner's addr, wdata and we into ram_addr, ram_data_in and op_we. Set last_grant=winner. Go to ACC.
  - No req: stay in IDLE; all RAM controls 0.
- ACC (exactly 1 cycle):
  - Assert the winner's port enable (A for 0, B for 1) and gnt of the winner.
  - ram_wr_en = op_we.
  - Next state: RD if read, IDLE if write.
- RD (1 cycle):
  - All enables 0.
  - Capture the winner's port output into rdata at the end of the cycle.
  - rvalid of the winner pulses the following cycle (the IDLE cycle) while the FSM resumes arbitration.
- Latency from req sampled high in IDLE at cycle T:
  - Write: gnt at T+1, RAM written at end of T+1; next arbitration possible at T+2.
  - Read: gnt at T+1, rvalid and rdata at T+3; next arbitration at T+3.
- Requesters may drop req in the cycle after gnt. A req held high after gnt is treated as a new request.
- A req dropped before gnt is ignored only if it is low in IDLE. Once selected, the transaction completes.
- Fairness: under continuous dual requests, grants strictly alternate 0,1,0,1...
- Read-after-write to the same address by the other requester returns the new data; no bypass is needed because accesses are serialised.
- Outputs are registered except gnt and the RAM enables, which decode from state plus the registered winner id.
- At most one gnt, one port enable and one rvalid are high in any cycle.
- rdata holds its value between reads.

Decomposition:
- Shared package holds the state encoding (IDLE=2'd0, ACC=2'd1, RD=2'd2), the ADDR_W/DATA_W defaults and the requester-id constants (REQ_A=0, REQ_B=1).
- One natural sub-module: rr_pick2, the combinational 2-way round-robin selector (inputs req0, req1, last_grant; outputs valid, winner).

Test Plan:
- Reset mid-read: assert rst_n=0 during RD -> rvalid never pulses, all outputs 0, next grant goes to requester 0.
- Single write: req0=1, we0=1, addr0=5, wdata0=0xAA -> gnt0 one cycle later with ram_port_A_enb=1, ram_wr_en=1, ram_addr=5, ram_data_in=0xAA.
- Read-back on port B: req1=1, we1=0, addr1=5 -> gnt1 at T+1, rvalid1 at T+3 with rdata=0xAA; port A enable never asserted.
- Contention: req0 and req1 held high simultaneously for 6 writes (addr 1..3 each) -> gnt order 0,1,0,1,0,1, never both high in one cycle.
- Overwrite then cross-read: requester 1 writes 0xCC to addr 5, then requester 0 reads addr 5 -> rvalid0 with rdata=0xCC.
- Boundary addresses: write 0x55 to addr 31 and 0x33 to addr 0, then read both -> 0x55 and 0x33, with no aliasing.

Source files
------------

// File: rtl/dpram_rr_arbiter_pkg.sv
// Shared definitions for the dual-port RAM round-robin arbiter slice:
// FSM encoding, default widths and requester ids.
package dpram_rr_arbiter_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RD   = 2'd2
  } state_t;

endpackage

// File: rtl/dpram_rr_arbiter_if.sv
// Requester handshakes plus the RAM-side bus of the arbiter.
// The arbiter sits on the slave modport; requesters and the RAM sit on master.
interface dpram_rr_arbiter_if
  import dpram_rr_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_in;
  logic              ram_wr_en;
  logic              ram_port_A_enb, ram_port_B_enb;
  logic [DATA_W-1:0] ram_data_out_A, ram_data_out_B;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  ram_data_out_A, ram_data_out_B,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
    output ram_addr, ram_data_in, ram_wr_en, ram_port_A_enb, ram_port_B_enb
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output ram_data_out_A, ram_data_out_B,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
    input  ram_addr, ram_data_in, ram_wr_en, ram_port_A_enb, ram_port_B_enb
  );

endinterface

// File: rtl/dpram_rr_arbiter_rr_pick2.sv
// Combinational 2-way round-robin selector: a lone request wins outright,
// a tie goes to the requester that did not win last time.
module rr_pick2
  import dpram_rr_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = req0 | req1;
    winner = REQ_A;
    if (req0 && req1) winner = ~last_grant;
    else if (req1)    winner = REQ_B;
  end

endmodule

// File: rtl/dpram_rr_arbiter.sv
// Serialises two requesters onto a shared-address dual-port RAM:
// IDLE arbitrates, ACC drives the winner's port, RD captures read data.
module dpram_rr_arbiter
  import dpram_rr_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic          clk,
  input logic          rst_n,
  dpram_rr_arbiter_if.slave bus
);

  state_t            state;
  logic              winner;
  logic              last_grant;
  logic              op_we;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              wr_en_q;
  logic              rvalid0_q, rvalid1_q;

  logic              pick_valid;
  logic              pick_winner;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_pick2 u_pick (
    .req0       (bus.req0),
    .req1       (bus.req1),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  always_comb begin
    sel_we    = bus.we0;
    sel_addr  = bus.addr0;
    sel_wdata = bus.wdata0;
    if (pick_winner == REQ_B) begin
      sel_we    = bus.we1;
      sel_addr  = bus.addr1;
      sel_wdata = bus.wdata1;
    end
  end

  // wr_en is registered alongside the address so it is high exactly in ACC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      winner     <= REQ_A;
      last_grant <= REQ_B;
      op_we      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      wr_en_q    <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      wr_en_q   <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            winner     <= pick_winner;
            last_grant <= pick_winner;
            op_we      <= sel_we;
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
            wr_en_q    <= sel_we;
            state      <= ACC;
          end
        end
        ACC: state <= op_we ? IDLE : RD;
        RD: begin
          rdata_q   <= (winner == REQ_B) ? bus.ram_data_out_B : bus.ram_data_out_A;
          rvalid0_q <= (winner == REQ_A);
          rvalid1_q <= (winner == REQ_B);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0           = (state == ACC) && (winner == REQ_A);
  assign bus.gnt1           = (state == ACC) && (winner == REQ_B);
  assign bus.ram_port_A_enb = bus.gnt0;
  assign bus.ram_port_B_enb = bus.gnt1;
  assign bus.ram_wr_en      = wr_en_q;
  assign bus.ram_addr       = addr_q;
  assign bus.ram_data_in    = wdata_q;
  assign bus.rdata          = rdata_q;
  assign bus.rvalid0        = rvalid0_q;
  assign bus.rvalid1        = rvalid1_q;

endmodule
